// File: rtl/surface_shader_if.sv
// Stream bundle for surface_shader: vector input strobe, pixel valid/ready output, status.
// Vectors pack {x[95:64], y[63:32], z[31:0]}, each Q8.24 signed.
interface surface_shader_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                          valid_in;
    logic [95:0]                   normal_in;
    logic [95:0]                   light_in;
    logic                          pixel_valid;
    logic                          pixel_ready;
    logic [23:0]                   pixel_data;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output valid_in, normal_in, light_in, pixel_ready,
        input  pixel_valid, pixel_data, overflow, fifo_level
    );

    modport slave (
        input  valid_in, normal_in, light_in, pixel_ready,
        output pixel_valid, pixel_data, overflow, fifo_level
    );
endinterface

// File: rtl/surface_shader.sv
// Lambertian shader: input FIFO absorbs unthrottled vector strobes, then a three-stage
// pipeline (dot product, clamped intensity, colour scale) feeds a valid/ready pixel port.
module surface_shader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] AMBIENT    = 32'h0033_3333,
    parameter logic [7:0]  BASE_R     = 8'd255,
    parameter logic [7:0]  BASE_G     = 8'd128,
    parameter logic [7:0]  BASE_B     = 8'd0
) (
    input logic             clk,
    input logic             rst_n,
    surface_shader_if.slave bus
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam logic [31:0] FpOne = 32'h0100_0000;

    // Signed Q8.24 multiply: full Q16.48 product, keep bits [55:24].
    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] a_ext;
        logic signed [63:0] b_ext;
        logic signed [63:0] prod;
        a_ext = {{32{a[31]}}, a};
        b_ext = {{32{b[31]}}, b};
        prod  = a_ext * b_ext;
        return 32'(prod >>> 24);
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] base, input logic [31:0] inten);
        logic [39:0] prod;
        prod = {32'd0, base} * {8'd0, inten};
        return 8'(prod >> 24);
    endfunction

    // FIFO storage and control
    logic [191:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    // Pipeline registers
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_dot_q, s1_dot_d;
    logic            s2_valid_q, s2_valid_d;
    logic [31:0]     s2_int_q, s2_int_d;
    logic            pix_valid_q, pix_valid_d;
    logic [23:0]     pix_data_q, pix_data_d;

    logic            stall;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [191:0]    head;
    logic [31:0]     dot;
    logic [31:0]     diff;
    logic [32:0]     lit_sum;
    logic [31:0]     inten;

    assign stall      = pix_valid_q && !bus.pixel_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign pop        = !stall && !fifo_empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push       = bus.valid_in && (!fifo_full || pop);
    assign drop       = bus.valid_in && fifo_full && !pop;
    assign head       = fifo_mem_q[rd_ptr_q];

    // S1 datapath: head = {nx, ny, nz, lx, ly, lz}
    always_comb begin
        dot = fx_mul(head[191:160], head[95:64])
            + fx_mul(head[159:128], head[63:32])
            + fx_mul(head[127:96],  head[31:0]);
    end

    // S2 datapath: clamp diffuse to [0, 1], add ambient, clamp to 1
    always_comb begin
        diff = s1_dot_q;
        if (s1_dot_q[31]) begin
            diff = '0;
        end else if (s1_dot_q > FpOne) begin
            diff = FpOne;
        end
        lit_sum = {1'b0, AMBIENT} + {1'b0, diff};
        inten   = (lit_sum > {1'b0, FpOne}) ? FpOne : lit_sum[31:0];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q || drop;
        s1_valid_d  = s1_valid_q;
        s1_dot_d    = s1_dot_q;
        s2_valid_d  = s2_valid_q;
        s2_int_d    = s2_int_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        if (!stall) begin
            s1_valid_d  = pop;
            s2_valid_d  = s1_valid_q;
            pix_valid_d = s2_valid_q;
            if (pop) begin
                s1_dot_d = dot;
            end
            if (s1_valid_q) begin
                s2_int_d = inten;
            end
            if (s2_valid_q) begin
                pix_data_d = {scale(BASE_R, s2_int_q), scale(BASE_G, s2_int_q),
                              scale(BASE_B, s2_int_q)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_dot_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_int_q    <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            s1_valid_q  <= s1_valid_d;
            s1_dot_q    <= s1_dot_d;
            s2_valid_q  <= s2_valid_d;
            s2_int_q    <= s2_int_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.normal_in, bus.light_in};
        end
    end

    assign bus.pixel_valid = pix_valid_q;
    assign bus.pixel_data  = pix_data_q;
    assign bus.overflow    = overflow_q;
    assign bus.fifo_level  = count_q;

endmodule

// File: tb/tb_surface_shader.sv
// Directed bench for surface_shader: latency, clamping, burst order, stall/overflow,
// simultaneous push/pop at full, and asynchronous reset mid-flight.
module tb_surface_shader;

    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    surface_shader_if #(.FIFO_DEPTH(Depth)) bus ();

    surface_shader #(.FIFO_DEPTH(Depth)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [95:0] nrm_tbl [8];
    logic [95:0] lgt_tbl [8];
    logic [23:0] pix_tbl [8];
    logic [23:0] got [20];
    int          n_got;
    int          max_lvl;
    int          pv_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic set_in(input logic v, input int idx);
        bus.valid_in  = v;
        bus.normal_in = nrm_tbl[idx];
        bus.light_in  = lgt_tbl[idx];
    endtask

    task automatic run_single(input int idx, input string tag);
        int lat;
        @(negedge clk);
        set_in(1'b1, idx);
        @(negedge clk);
        set_in(1'b0, 0);
        lat = 0;
        while (!bus.pixel_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 3);
        check_eq({tag, "_pix"}, {8'd0, bus.pixel_data}, {8'd0, pix_tbl[idx]});
        check_eq({tag, "_ovf"}, {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_width"}, {31'd0, bus.pixel_valid}, 32'd0);
    endtask

    task automatic collect(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (bus.pixel_valid && n_got < 20) begin
                got[n_got] = bus.pixel_data;
                n_got++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // {x, y, z}; 1.0 = 0x01000000
        nrm_tbl[0] = {32'h0, 32'h0, 32'h0100_0000};        lgt_tbl[0] = {32'h0, 32'h0, 32'h0100_0000};
        nrm_tbl[1] = {32'h0, 32'h0, 32'h0100_0000};        lgt_tbl[1] = {32'h0, 32'h0, 32'hFF00_0000};
        nrm_tbl[2] = {32'h0, 32'h0, 32'h0100_0000};        lgt_tbl[2] = {32'h0, 32'h0, 32'h0080_0000};
        nrm_tbl[3] = {32'h0100_0000, 32'h0, 32'h0};        lgt_tbl[3] = {32'h0040_0000, 32'h0, 32'h0};
        nrm_tbl[4] = {32'h0, 32'h0, 32'h0100_0000};        lgt_tbl[4] = {32'h0, 32'h0, 32'h00C0_0000};
        nrm_tbl[5] = {32'h0, 32'h0100_0000, 32'h0};        lgt_tbl[5] = {32'h0, 32'h0020_0000, 32'h0};
        nrm_tbl[6] = {32'h0080_0000, 32'h0080_0000, 32'h0};
        lgt_tbl[6] = {32'h0040_0000, 32'h0080_0000, 32'h0};
        nrm_tbl[7] = {32'h0, 32'h0, 32'h0100_0000};        lgt_tbl[7] = {32'h0, 32'h0, 32'h0010_0000};
        // i = 1.0, 0.2, 0.7, 0.45, 0.95, 0.325, 0.575, 0.2625
        pix_tbl[0] = 24'hFF8000;  pix_tbl[1] = 24'h321900;
        pix_tbl[2] = 24'hB25900;  pix_tbl[3] = 24'h723900;
        pix_tbl[4] = 24'hF27900;  pix_tbl[5] = 24'h522900;
        pix_tbl[6] = 24'h924900;  pix_tbl[7] = 24'h422100;

        set_in(1'b0, 0);
        bus.pixel_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_pv",  {31'd0, bus.pixel_valid}, 32'd0);
        check_eq("rst_pix", {8'd0, bus.pixel_data}, 32'd0);
        check_eq("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check_eq("rst_lvl", {29'd0, bus.fifo_level}, 32'd0);
        rst_n = 1'b1;

        run_single(0, "lit");
        run_single(1, "back");
        run_single(2, "half");

        // Burst with ready high: one pixel per cycle, in order
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c >= 4 && c < 12) begin
                check_eq("burst_pv",  {31'd0, bus.pixel_valid}, 32'd1);
                check_eq("burst_pix", {8'd0, bus.pixel_data}, {8'd0, pix_tbl[c-4]});
            end else begin
                check_eq("burst_idle", {31'd0, bus.pixel_valid}, 32'd0);
            end
            set_in(c < 8, (c < 8) ? c : 0);
        end

        // Continuous stall: 7 held, 8th dropped
        bus.pixel_ready = 1'b0;
        max_lvl = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            if (c == 7) begin
                check_eq("stall_ovf_pre", {31'd0, bus.overflow}, 32'd0);
                check_eq("stall_lvl_full", {29'd0, bus.fifo_level}, 32'd4);
            end
            if (c == 8) check_eq("stall_ovf_set", {31'd0, bus.overflow}, 32'd1);
            if (c >= 4) begin
                check_eq("stall_pv",  {31'd0, bus.pixel_valid}, 32'd1);
                check_eq("stall_pix", {8'd0, bus.pixel_data}, {8'd0, pix_tbl[0]});
            end
            set_in(c < 8, (c < 8) ? c : 0);
        end
        check_eq("stall_peak", max_lvl, 4);
        bus.pixel_ready = 1'b1;
        n_got = 0;
        collect(20);
        check_eq("drain_cnt", n_got, 7);
        for (int k = 0; k < 7; k++) begin
            check_eq("drain_pix", {8'd0, got[k]}, {8'd0, pix_tbl[k]});
        end
        check_eq("drain_lvl", {29'd0, bus.fifo_level}, 32'd0);
        check_eq("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        rst_n = 1'b0;
        @(negedge clk);
        check_eq("ovf_clear", {31'd0, bus.overflow}, 32'd0);
        rst_n = 1'b1;

        // Fill to capacity, then release the stall on the same cycle as a new strobe
        bus.pixel_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            set_in(c < 7, (c < 7) ? c : 0);
        end
        @(negedge clk);
        check_eq("full_lvl", {29'd0, bus.fifo_level}, 32'd4);
        check_eq("full_pv",  {31'd0, bus.pixel_valid}, 32'd1);
        n_got = 0;
        got[0] = bus.pixel_data;
        n_got = 1;
        bus.pixel_ready = 1'b1;
        set_in(1'b1, 7);
        @(negedge clk);
        set_in(1'b0, 0);
        check_eq("same_lvl", {29'd0, bus.fifo_level}, 32'd4);
        check_eq("same_ovf", {31'd0, bus.overflow}, 32'd0);
        collect(20);
        check_eq("same_cnt", n_got, 8);
        for (int k = 0; k < 8; k++) begin
            check_eq("same_pix", {8'd0, got[k]}, {8'd0, pix_tbl[k]});
        end

        // Asynchronous reset with items in flight
        bus.pixel_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_in(c < 3, (c < 3) ? c : 0);
        end
        check_eq("flight_pv", {31'd0, bus.pixel_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pv",  {31'd0, bus.pixel_valid}, 32'd0);
        check_eq("arst_pix", {8'd0, bus.pixel_data}, 32'd0);
        check_eq("arst_lvl", {29'd0, bus.fifo_level}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pixel_ready = 1'b1;
        pv_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.pixel_valid) pv_cnt++;
        end
        check_eq("no_stale", pv_cnt, 0);
        run_single(2, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
